// File: rtl/jk_flop_bank_if.sv
// Bus bundle for jk_flop_bank: per-channel J/K inputs, mode select, synchronous clear,
// and the registered channel state with its update/change/error strobes.
interface jk_flop_bank_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [1:0]       mode;
    logic             sync_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tick;
    logic             chg;
    logic             err;

    modport master (
        output j, k, mode, sync_clr,
        input  q, q_bar, tick, chg, err
    );

    modport slave (
        input  j, k, mode, sync_clr,
        output q, q_bar, tick, chg, err
    );
endinterface

// File: rtl/jk_flop_bank.sv
// Bank of WIDTH independent JK/T/D/SR flip-flops that only update on a prescaled
// clock-enable; the prescaler never produces a derived clock.
module jk_flop_bank #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIVISOR = 100000000
) (
    input  logic          clk,
    input  logic          reset,
    jk_flop_bank_if.slave bus
);
    localparam logic [1:0]  MODE_JK  = 2'b00;
    localparam logic [1:0]  MODE_T   = 2'b01;
    localparam logic [1:0]  MODE_D   = 2'b10;
    localparam logic [1:0]  MODE_SR  = 2'b11;
    localparam logic [27:0] CNT_LAST = 28'(DIVISOR - 32'd1);

    // Per-bit next state; an SR bit with both inputs high holds (flagged separately).
    function automatic logic [WIDTH-1:0] next_state(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] jv,
        input logic [WIDTH-1:0] kv,
        input logic [1:0]       md
    );
        logic [WIDTH-1:0] nxt;
        case (md)
            MODE_JK: nxt = (jv & ~cur) | (~kv & cur);
            MODE_T:  nxt = cur ^ jv;
            MODE_D:  nxt = jv;
            MODE_SR: nxt = (jv & ~kv) | (cur & ~(jv ^ kv));
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    function automatic logic sr_conflict(
        input logic [WIDTH-1:0] jv,
        input logic [WIDTH-1:0] kv,
        input logic [1:0]       md
    );
        return (md == MODE_SR) && ((jv & kv) != '0);
    endfunction

    logic [27:0]      cnt_q;
    logic [27:0]      cnt_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tick_q;
    logic             tick_d;
    logic             chg_q;
    logic             chg_d;
    logic             err_q;
    logic             err_d;
    logic             update_cycle;

    // Prescaler wrap detection and next-state of channels and flags.
    always_comb begin
        update_cycle = (cnt_q == CNT_LAST);
        cnt_d        = cnt_q + 28'd1;
        q_d          = q_q;
        err_d        = err_q;
        if (update_cycle) begin
            cnt_d = 28'd0;
            q_d   = next_state(q_q, bus.j, bus.k, bus.mode);
            err_d = err_q | sr_conflict(bus.j, bus.k, bus.mode);
        end else begin
            cnt_d = cnt_q + 28'd1;
            q_d   = q_q;
            err_d = err_q;
        end
        tick_d = update_cycle;
        chg_d  = update_cycle && (q_d != q_q);
    end

    // State registers; sync_clr outranks a coincident update cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 28'd0;
            q_q    <= '0;
            tick_q <= 1'b0;
            chg_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (bus.sync_clr) begin
            cnt_q  <= 28'd0;
            q_q    <= '0;
            tick_q <= 1'b0;
            chg_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            tick_q <= tick_d;
            chg_q  <= chg_d;
            err_q  <= err_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.q_bar = ~q_q;
    assign bus.tick  = tick_q;
    assign bus.chg   = chg_q;
    assign bus.err   = err_q;
endmodule
